// File: rtl/axil_seq_master.sv
// AXI4-Lite self-test initiator: writes SEED+i to BASE+4*i, reads each word back and compares.
// Latency: at least 3 cycles per write and 3 per read, with one transaction outstanding at a time.
// Backpressure: VALIDs are held until READY; the AXIL_MST_TIMEOUT_EN macro adds a watchdog that aborts stalled handshakes.
module axil_seq_master #(
    parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h0000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH   = 32,
    parameter int          C_M_AXI_DATA_WIDTH   = 32,
    parameter int          C_TRANSACTIONS_NUM   = 4,
    parameter logic [31:0] C_DATA_SEED          = 32'h0000_0001,
    parameter int          C_TIMEOUT_CYCLES     = 256
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_TXN,
    output logic                            BUSY,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic                            TIMEOUT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int IDX_W = (C_TRANSACTIONS_NUM > 1) ? $clog2(C_TRANSACTIONS_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(C_TRANSACTIONS_NUM - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_BASE_ADDR);
    localparam logic [C_M_AXI_DATA_WIDTH-1:0] SEED = C_M_AXI_DATA_WIDTH'(C_DATA_SEED);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_DATA,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             init_q;
    logic             start;
    logic             aw_done;
    logic             w_done;
    logic             load_wr;
    logic             load_rd;
    logic             enter_done;
    logic             wd_expire;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic [C_M_AXI_DATA_WIDTH-1:0] exp_rdata;

    assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs   = M_AXI_BVALID  & M_AXI_BREADY;
    assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs   = M_AXI_RVALID  & M_AXI_RREADY;
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // Start only acts from IDLE; edges during a run are dropped.
    assign start     = INIT_TXN & ~init_q & ~BUSY & (state == IDLE);
    assign exp_rdata = SEED + C_M_AXI_DATA_WIDTH'(idx);

    logic unused_resp_lsb;
    assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

`ifdef AXIL_MST_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        in_wait;

    assign in_wait   = (state == WR_ISSUE) || (state == WR_RESP) ||
                       (state == RD_ISSUE) || (state == RD_DATA);
    assign wd_expire = in_wait && !any_hs && (wd_cnt == 16'(C_TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd_cnt <= '0;
        end else if (!in_wait || any_hs) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (C_TIMEOUT_CYCLES == 0);
    assign wd_expire          = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        load_wr    = 1'b0;
        load_rd    = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WR_ISSUE;
                    idx_nxt   = '0;
                    load_wr   = 1'b1;
                end
            end
            WR_ISSUE: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    if (idx == LAST) begin
                        idx_nxt   = '0;
                        state_nxt = RD_ISSUE;
                        load_rd   = 1'b1;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = WR_ISSUE;
                        load_wr   = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                if (ar_hs) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    if (idx == LAST) begin
                        idx_nxt    = '0;
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = RD_ISSUE;
                        load_rd   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Watchdog abort overrides any pending transition.
        if (wd_expire) begin
            state_nxt  = DONE;
            idx_nxt    = '0;
            load_wr    = 1'b0;
            load_rd    = 1'b0;
            enter_done = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q        <= 1'b0;
            idx           <= '0;
            BUSY          <= 1'b0;
            TXN_DONE      <= 1'b0;
            ERROR         <= 1'b0;
            TIMEOUT       <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            init_q <= INIT_TXN;
            idx    <= idx_nxt;

            if (start) begin
                BUSY     <= 1'b1;
                TXN_DONE <= 1'b0;
                ERROR    <= 1'b0;
                TIMEOUT  <= 1'b0;
            end

            // AW and W retire independently; aw_done/w_done remember which one already went.
            if (load_wr) begin
                M_AXI_AWADDR  <= BASE + C_M_AXI_ADDR_WIDTH'({idx_nxt, 2'b00});
                M_AXI_WDATA   <= SEED + C_M_AXI_DATA_WIDTH'(idx_nxt);
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
            end else begin
                if (aw_hs) begin
                    M_AXI_AWVALID <= 1'b0;
                    aw_done       <= 1'b1;
                end
                if (w_hs) begin
                    M_AXI_WVALID <= 1'b0;
                    w_done       <= 1'b1;
                end
            end

            if (load_rd) begin
                M_AXI_ARADDR  <= BASE + C_M_AXI_ADDR_WIDTH'({idx_nxt, 2'b00});
                M_AXI_ARVALID <= 1'b1;
            end else if (ar_hs) begin
                M_AXI_ARVALID <= 1'b0;
            end

            // Single-cycle ready pulses, raised the cycle after the slave's VALID is seen.
            M_AXI_BREADY <= (state == WR_RESP) && M_AXI_BVALID && !M_AXI_BREADY;
            M_AXI_RREADY <= (state == RD_DATA) && M_AXI_RVALID && !M_AXI_RREADY;

            if (b_hs && M_AXI_BRESP[1]) begin
                ERROR <= 1'b1;
            end
            if (r_hs && ((M_AXI_RDATA != exp_rdata) || M_AXI_RRESP[1])) begin
                ERROR <= 1'b1;
            end

            if (enter_done) begin
                BUSY     <= 1'b0;
                TXN_DONE <= 1'b1;
            end

            if (wd_expire) begin
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                TIMEOUT       <= 1'b1;
                ERROR         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_seq_master.sv
// Directed bench for axil_seq_master with a small AXI4-Lite slave model (delays, error and corruption knobs).
module tb_axil_seq_master;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 256;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        INIT_TXN;
    logic        BUSY, TXN_DONE, ERROR, TIMEOUT;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int checks   = 0;
    int failures = 0;

    // Slave knobs
    int   aw_delay      = 0;
    int   w_delay       = 0;
    int   bresp_err_idx = -1;
    logic corrupt       = 1'b0;
    logic ar_stuck      = 1'b0;
    logic clr_mon       = 1'b0;

    always #5 ACLK = ~ACLK;

    axil_seq_master #(
        .C_M_TARGET_BASE_ADDR(32'h0000_0000),
        .C_M_AXI_ADDR_WIDTH  (32),
        .C_M_AXI_DATA_WIDTH  (32),
        .C_TRANSACTIONS_NUM  (4),
        .C_DATA_SEED         (32'h0000_0001),
        .C_TIMEOUT_CYCLES    (TO_CYC)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .INIT_TXN     (INIT_TXN),
        .BUSY         (BUSY),
        .TXN_DONE     (TXN_DONE),
        .ERROR        (ERROR),
        .TIMEOUT      (TIMEOUT),
        .M_AXI_AWADDR (M_AXI_AWADDR),
        .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA  (M_AXI_WDATA),
        .M_AXI_WSTRB  (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_WREADY (M_AXI_WREADY),
        .M_AXI_BRESP  (M_AXI_BRESP),
        .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BREADY (M_AXI_BREADY),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [0:15];
    int          aw_wait, w_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_lat, w_lat;
    logic        s_aw_hs, s_w_hs, s_ar_hs, wr_fire;
    logic [31:0] wa, wd;

    assign M_AXI_AWREADY = (aw_wait >= aw_delay);
    assign M_AXI_WREADY  = (w_wait >= w_delay);
    assign M_AXI_ARREADY = !ar_stuck;
    assign s_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign s_w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign s_ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign wa      = s_aw_hs ? M_AXI_AWADDR : aw_lat;
    assign wd      = s_w_hs ? M_AXI_WDATA : w_lat;
    assign wr_fire = (aw_got || s_aw_hs) && (w_got || s_w_hs);

    int wr_total, rd_total, busy_cyc, aw_hi, w_hi, unstable;
    int wr_idx [0:15];
    logic        aw_pend;
    logic [31:0] aw_prev;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_lat <= '0; w_lat <= '0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
        end else begin
            if (s_aw_hs) aw_wait <= 0; else if (M_AXI_AWVALID) aw_wait <= aw_wait + 1;
            if (s_w_hs) w_wait <= 0; else if (M_AXI_WVALID) w_wait <= w_wait + 1;
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (wr_fire) begin
                mem[wa[5:2]] <= wd;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP  <= (wr_total == bresp_err_idx) ? 2'b10 : 2'b00;
            end else begin
                if (s_aw_hs) begin aw_got <= 1'b1; aw_lat <= M_AXI_AWADDR; end
                if (s_w_hs) begin w_got <= 1'b1; w_lat <= M_AXI_WDATA; end
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (s_ar_hs) begin
                M_AXI_RVALID <= 1'b1;
                M_AXI_RRESP  <= 2'b00;
                M_AXI_RDATA  <= (corrupt && M_AXI_ARADDR == 32'h8) ? 32'hDEAD_BEEF : mem[M_AXI_ARADDR[5:2]];
            end
        end
    end

    always @(posedge ACLK) begin
        if (clr_mon) begin
            wr_total <= 0; rd_total <= 0; busy_cyc <= 0; aw_hi <= 0; w_hi <= 0; unstable <= 0;
            aw_pend <= 1'b0; aw_prev <= '0;
            for (int i = 0; i < 16; i++) wr_idx[i] <= 0;
        end else begin
            if (wr_fire) begin
                wr_total <= wr_total + 1;
                wr_idx[wa[5:2]] <= wr_idx[wa[5:2]] + 1;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) rd_total <= rd_total + 1;
            if (BUSY) busy_cyc <= busy_cyc + 1;
            if (M_AXI_AWVALID) aw_hi <= aw_hi + 1;
            if (M_AXI_WVALID) w_hi <= w_hi + 1;
            if (aw_pend && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_prev)) unstable <= unstable + 1;
            aw_pend <= M_AXI_AWVALID && !M_AXI_AWREADY;
            aw_prev <= M_AXI_AWADDR;
        end
    end

    // ---------------- helpers ----------------
    task automatic clr_monitor();
        @(negedge ACLK); clr_mon = 1'b1;
        @(negedge ACLK); clr_mon = 1'b0;
    endtask

    task automatic start_seq();
        @(negedge ACLK); INIT_TXN = 1'b1;
        @(negedge ACLK); INIT_TXN = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (TXN_DONE !== 1'b1 && n < 2000) begin @(negedge ACLK); n++; end
        checks++;
        if (TXN_DONE !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_wait: TXN_DONE=%b after %0d cycles, want 1", name, TXN_DONE, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESETN = 1'b0; INIT_TXN = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({BUSY, TXN_DONE, ERROR, TIMEOUT, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
             M_AXI_ARVALID, M_AXI_RREADY} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000000000", {BUSY, TXN_DONE, ERROR, TIMEOUT,
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        checks++;
        if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== 96'b0) begin
            failures++;
            $display("FAIL reset_addr_data: aw=%h ar=%h wd=%h want 0", M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA);
        end
        checks++;
        if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000 || M_AXI_WSTRB !== 4'hF) begin
            failures++;
            $display("FAIL reset_const: awprot=%b arprot=%b wstrb=%h want 000 000 f",
                     M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB);
        end
        @(negedge ACLK); ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_basic();
        logic [31:0] exp_mem [0:3];
        exp_mem[0] = 32'h1; exp_mem[1] = 32'h2; exp_mem[2] = 32'h3; exp_mem[3] = 32'h4;
        clr_monitor();
        start_seq();
        wait_done("basic");
        checks++;
        if (busy_cyc != 24) begin
            failures++; $display("FAIL basic_busy_cycles: got %0d want 24", busy_cyc);
        end
        checks++;
        if (BUSY !== 1'b0 || ERROR !== 1'b0 || TIMEOUT !== 1'b0) begin
            failures++; $display("FAIL basic_flags: busy=%b err=%b to=%b want 0 0 0", BUSY, ERROR, TIMEOUT);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                failures++; $display("FAIL basic_mem%0d: got %h want %h", i, mem[i], exp_mem[i]);
            end
        end
        checks++;
        if (wr_total != 4 || rd_total != 4) begin
            failures++; $display("FAIL basic_counts: wr=%0d rd=%0d want 4 4", wr_total, rd_total);
        end
    endtask

    task automatic test_aw_delay();
        aw_delay = 3; w_delay = 0;
        clr_monitor();
        start_seq();
        wait_done("awdly");
        checks++;
        if (aw_hi != 16 || w_hi != 4) begin
            failures++; $display("FAIL awdly_valid_cycles: aw=%0d w=%0d want 16 4", aw_hi, w_hi);
        end
        checks++;
        if (unstable != 0) begin
            failures++; $display("FAIL awdly_addr_stable: got %0d changes want 0", unstable);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_idx[i] != 1) begin
                failures++; $display("FAIL awdly_writes_idx%0d: got %0d want 1", i, wr_idx[i]);
            end
        end
        checks++;
        if (ERROR !== 1'b0) begin
            failures++; $display("FAIL awdly_error: got %b want 0", ERROR);
        end
        aw_delay = 0;
    endtask

    task automatic test_read_corrupt();
        corrupt = 1'b1;
        clr_monitor();
        start_seq();
        wait_done("corrupt");
        checks++;
        if (ERROR !== 1'b1 || rd_total != 4) begin
            failures++; $display("FAIL corrupt_err: err=%b reads=%0d want 1 4", ERROR, rd_total);
        end
        corrupt = 1'b0;
        clr_monitor();
        start_seq();
        checks++;
        if (ERROR !== 1'b0 || TXN_DONE !== 1'b0 || BUSY !== 1'b1) begin
            failures++; $display("FAIL rerun_clear: err=%b done=%b busy=%b want 0 0 1", ERROR, TXN_DONE, BUSY);
        end
        wait_done("rerun");
        checks++;
        if (ERROR !== 1'b0) begin
            failures++; $display("FAIL rerun_err: got %b want 0", ERROR);
        end
    endtask

    task automatic test_bresp_err();
        bresp_err_idx = 1;
        clr_monitor();
        start_seq();
        wait_done("bresp");
        checks++;
        if (ERROR !== 1'b1) begin
            failures++; $display("FAIL bresp_err: got %b want 1", ERROR);
        end
        checks++;
        if (wr_total != 4 || rd_total != 4) begin
            failures++; $display("FAIL bresp_counts: wr=%0d rd=%0d want 4 4", wr_total, rd_total);
        end
        bresp_err_idx = -1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clr_monitor();
        start_seq();
        while (!(BUSY === 1'b1 && M_AXI_ARVALID === 1'b0 && M_AXI_ARADDR === 32'h8) && n < 500) begin
            @(negedge ACLK); n++;
        end
        checks++;
        if (n >= 500) begin
            failures++; $display("FAIL rstmid_reach: RD_DATA idx2 not seen, araddr=%h", M_AXI_ARADDR);
        end
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({BUSY, TXN_DONE, ERROR, TIMEOUT, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
             M_AXI_ARVALID, M_AXI_RREADY} !== 9'b0 || M_AXI_ARADDR !== 32'h0 ||
            M_AXI_AWADDR !== 32'h0 || M_AXI_WDATA !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs: ctrl=%b ar=%h aw=%h wd=%h want all 0", {BUSY, TXN_DONE, ERROR,
                     TIMEOUT, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY},
                     M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA);
        end
        @(negedge ACLK); ARESETN = 1'b1;
        @(negedge ACLK);
        clr_monitor();
        start_seq();
        checks++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'h0 || M_AXI_WDATA !== 32'h1) begin
            failures++; $display("FAIL rstmid_first_write: awvalid=%b aw=%h wd=%h want 1 0 1",
                                 M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WDATA);
        end
        wait_done("rstmid");
        checks++;
        if (ERROR !== 1'b0 || wr_total != 4) begin
            failures++; $display("FAIL rstmid_rerun: err=%b wr=%0d want 0 4", ERROR, wr_total);
        end
    endtask

`ifdef AXIL_MST_TIMEOUT_EN
    task automatic test_timeout();
        int n  = 0;
        int hi = 0;
        ar_stuck = 1'b1;
        clr_monitor();
        start_seq();
        while (M_AXI_ARVALID !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        while (M_AXI_ARVALID === 1'b1 && hi < 100) begin @(negedge ACLK); hi++; end
        checks++;
        if (hi < 15 || hi > 17) begin
            failures++; $display("FAIL timeout_cycles: arvalid high %0d cycles want about 16", hi);
        end
        checks++;
        if (TIMEOUT !== 1'b1 || ERROR !== 1'b1 || TXN_DONE !== 1'b1 || M_AXI_ARVALID !== 1'b0) begin
            failures++; $display("FAIL timeout_flags: to=%b err=%b done=%b arvalid=%b want 1 1 1 0",
                                 TIMEOUT, ERROR, TXN_DONE, M_AXI_ARVALID);
        end
        ar_stuck = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_read_corrupt();
        test_bresp_err();
        test_reset_mid();
`ifdef AXIL_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_seq_master.md
Name: axil_seq_master

Overview:
- AXI4-Lite initiator that exercises the data BRAM controller's S00_AXI register window from RTL, with no VIP involved.
- On a start edge it performs C_TRANSACTIONS_NUM single-beat writes of an incrementing pattern to consecutive word addresses.
- It then reads the same addresses back and compares each read against the written pattern.
- Completion and a sticky error flag go to the beamformer TX control logic as a bring-up/self-test engine.

Parameters:
- C_M_TARGET_BASE_ADDR, 32'h0000_0000, base byte address of the target slave window.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_TRANSACTIONS_NUM, 4, number of write/read pairs, range 1..256.
- C_DATA_SEED, 32'h0000_0001, data written at index 0.
- C_TIMEOUT_CYCLES, 256, handshake watchdog limit; used only with AXIL_MST_TIMEOUT_EN.

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- INIT_TXN  in  1  start request, level; the rising edge starts a sequence
- BUSY  out  1  sequence in progress
- TXN_DONE  out  1  sequence finished, held until next start
- ERROR  out  1  sticky: bad response or data mismatch
- TIMEOUT  out  1  sticky watchdog flag; tied 0 without AXIL_MST_TIMEOUT_EN
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1  write address channel
- M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel; WSTRB fixed 4'hF
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1  read address channel
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset and constant outputs:
  - ARESETN low asynchronously clears all state.
  - All VALID/READY outputs, BUSY, TXN_DONE, ERROR, TIMEOUT and the index counter reset to 0.
  - AWADDR/ARADDR/WDATA reset to 0.
  - AWPROT/ARPROT are constant 3'b000.
  - Reset mid-sequence aborts cleanly; the next start begins at index 0.
- Start detection:
  - INIT_TXN is registered and a one-cycle start pulse is generated on its 0->1 transition.
  - Starts seen while BUSY=1 are ignored.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, DONE.
- IDLE:
  - On start: clear TXN_DONE, ERROR and TIMEOUT; set index=0, BUSY=1; go to WR_ISSUE.
- WR_ISSUE:
  - Drive AWADDR = BASE + 4*index and WDATA = SEED + index (mod 2^32).
  - Assert AWVALID and WVALID in the same cycle.
  - Each VALID drops independently the cycle after its READY is sampled high; the VALIDs are otherwise held stable.
  - When both channels have been accepted, go to WR_RESP.
- WR_RESP:
  - BREADY pulses high for exactly one cycle, registered, once BVALID is seen.
  - BRESP[1]=1 (SLVERR/DECERR) sets ERROR.
  - Then index++; if index==C_TRANSACTIONS_NUM, set index=0 and go to RD_ISSUE, else go to WR_ISSUE.
- RD_ISSUE:
  - ARADDR = BASE + 4*index; ARVALID held until ARREADY; then go to RD_DATA.
- RD_DATA:
  - RREADY pulses for one cycle on RVALID.
  - RDATA != SEED+index, or RRESP[1]=1, sets ERROR.
  - Then index++; after the last read go to DONE.
- DONE:
  - BUSY=0, TXN_DONE=1.
  - Return to IDLE in the same cycle; TXN_DONE/ERROR persist until the next start.
- Ordering and concurrency:
  - Exactly one transaction outstanding at any time; no read is issued before the last BRESP.
  - Ready signals arriving in the same cycle as VALID are accepted; minimum cost is 3 cycles per write and 3 cycles per read.
  - READY asserted before VALID is legal and must cause no extra transfer.

Optional Feature:
- Macro: AXIL_MST_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in any issue or response state without a handshake completing; it reloads on every handshake.
  - Reaching C_TIMEOUT_CYCLES sets TIMEOUT and ERROR, deasserts all VALID/READY, and forces DONE.
  - This violates AXI VALID-hold rules and is for debug builds only.
- Undefined: no counter; TIMEOUT tied 0; the FSM waits indefinitely.

Test Plan:
- Always-ready slave model, defaults, INIT_TXN 0->1:
  - Writes 1,2,3,4 land at 0x0,0x4,0x8,0xC.
  - Reads are returned; TXN_DONE=1, ERROR=0, BUSY low after 24 cycles.
- Slave with AWREADY delayed 3 cycles and WREADY delayed 0:
  - WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable.
  - Exactly one write per index.
- Slave corrupts the read at 0x8 (returns 0xDEAD_BEEF):
  - ERROR=1 at DONE, remaining reads still performed.
  - Next INIT_TXN edge clears ERROR and a clean rerun ends ERROR=0.
- Slave returns BRESP=2'b10 on the second write -> ERROR=1; sequence completes all 4 writes and 4 reads.
- ARESETN pulsed low during RD_DATA of index 2:
  - All outputs 0 immediately.
  - A new start writes index 0 first (AWADDR=0x0, WDATA=1).
- With AXIL_MST_TIMEOUT_EN, C_TIMEOUT_CYCLES=16, ARREADY stuck 0:
  - TIMEOUT=1, ERROR=1, TXN_DONE=1 about 16 cycles after ARVALID rises; ARVALID returns to 0.
